// File: rtl/rgb2gray_pipe.sv
// rgb2gray_pipe: three-stage RGB to grayscale converter with a valid/ready stall handshake.
//   S1 captures the pixel, S2 forms the weighted products, and S3 sums, rounds,
//   saturates and scales the result to the output width.
//   Each pixel selects its own weighting: equal average or BT.601 luma.
//   The sideband travels with its pixel through every stage.
// Optional build macro RGB2GRAY_THRESH_EN adds the in_thr input and the out_bin
// output (1 when gray >= the threshold of that same pixel).
module rgb2gray_pipe #(
    parameter int CH_W  = 4,
    parameter int OUT_W = 4,
    parameter int FRAC  = 10,
    parameter int SB_W  = 3
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3*CH_W-1:0] in_rgb,
    input  logic              in_mode,
    input  logic [SB_W-1:0]   in_sb,
`ifdef RGB2GRAY_THRESH_EN
    input  logic [OUT_W-1:0]  in_thr,
    output logic [0:0]        out_bin,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_gray,
    output logic [SB_W-1:0]   out_sb
);

    localparam int P_W = CH_W + FRAC;
    localparam int S_W = P_W + 2;
    localparam int Y_W = CH_W + 2;

    // Q0.FRAC weights; the luma weights are rounded to nearest.
    localparam logic [FRAC-1:0] W_EQ = FRAC'((1 << FRAC) / 3);
    localparam logic [FRAC-1:0] W_LR = FRAC'((299 * (1 << FRAC) + 500) / 1000);
    localparam logic [FRAC-1:0] W_LG = FRAC'((587 * (1 << FRAC) + 500) / 1000);
    localparam logic [FRAC-1:0] W_LB = FRAC'((114 * (1 << FRAC) + 500) / 1000);
    localparam logic [S_W-1:0]  HALF  = S_W'(1 << (FRAC - 1));
    localparam logic [Y_W-1:0]  Y_MAX = Y_W'((1 << CH_W) - 1);

    // One advance enable for the whole pipe; bubbles shift like data.
    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    logic              s1_valid;
    logic [CH_W-1:0]   s1_r, s1_g, s1_b;
    logic              s1_mode;
    logic [SB_W-1:0]   s1_sb;

    logic              s2_valid;
    logic [P_W-1:0]    s2_pr, s2_pg, s2_pb;
    logic [SB_W-1:0]   s2_sb;

`ifdef RGB2GRAY_THRESH_EN
    logic [OUT_W-1:0]  s1_thr, s2_thr;
`endif

    logic [FRAC-1:0]   wr, wg, wb;
    logic [P_W-1:0]    pr, pg, pb;
    logic [S_W-1:0]    sum;
    logic [Y_W-1:0]    y_wide;
    logic [CH_W-1:0]   y_sat;
    logic [OUT_W-1:0]  gray_d;

    assign wr = s1_mode ? W_LR : W_EQ;
    assign wg = s1_mode ? W_LG : W_EQ;
    assign wb = s1_mode ? W_LB : W_EQ;

    // Zero-extend both operands so each product is formed at full width.
    assign pr = {{FRAC{1'b0}}, s1_r} * {{CH_W{1'b0}}, wr};
    assign pg = {{FRAC{1'b0}}, s1_g} * {{CH_W{1'b0}}, wg};
    assign pb = {{FRAC{1'b0}}, s1_b} * {{CH_W{1'b0}}, wb};

    assign sum    = S_W'(s2_pr) + S_W'(s2_pg) + S_W'(s2_pb) + HALF;
    assign y_wide = sum[S_W-1:FRAC];
    assign y_sat  = (y_wide > Y_MAX) ? {CH_W{1'b1}} : y_wide[CH_W-1:0];

    // Scale to OUT_W: left-justify y and repeat its MSBs into the low bits.
    // A narrower output simply keeps the MSBs.
    always_comb begin
        gray_d = '0;
        for (int i = 0; i < OUT_W; i++)
            gray_d[OUT_W-1-i] = y_sat[CH_W-1-(i % CH_W)];
    end

    // S1: capture the pixel, its mode and its sideband.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_mode  <= 1'b0;
            s1_sb    <= '0;
`ifdef RGB2GRAY_THRESH_EN
            s1_thr   <= '0;
`endif
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_r     <= in_rgb[3*CH_W-1:2*CH_W];
            s1_g     <= in_rgb[2*CH_W-1:CH_W];
            s1_b     <= in_rgb[CH_W-1:0];
            s1_mode  <= in_mode;
            s1_sb    <= in_sb;
`ifdef RGB2GRAY_THRESH_EN
            s1_thr   <= in_thr;
`endif
        end
    end

    // S2: register the three weighted products.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_pr    <= '0;
            s2_pg    <= '0;
            s2_pb    <= '0;
            s2_sb    <= '0;
`ifdef RGB2GRAY_THRESH_EN
            s2_thr   <= '0;
`endif
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_pr    <= pr;
            s2_pg    <= pg;
            s2_pb    <= pb;
            s2_sb    <= s1_sb;
`ifdef RGB2GRAY_THRESH_EN
            s2_thr   <= s1_thr;
`endif
        end
    end

    // S3: register the rounded, saturated and scaled gray value as the output.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_gray  <= '0;
            out_sb    <= '0;
`ifdef RGB2GRAY_THRESH_EN
            out_bin   <= 1'b0;
`endif
        end else if (adv) begin
            out_valid <= s2_valid;
            out_gray  <= gray_d;
            out_sb    <= s2_sb;
`ifdef RGB2GRAY_THRESH_EN
            out_bin   <= (gray_d >= s2_thr);
`endif
        end
    end

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// tb_rgb2gray_pipe: checks the converter against an arithmetic reference.
// A 4-bit-output instance and an 8-bit-output instance share the same stimulus.
module tb_rgb2gray_pipe;

    logic        pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        rst_n, in_valid, in_mode, out_ready;
    logic [11:0] in_rgb;
    logic [2:0]  in_sb;
    logic        in_ready, out_valid, in_ready8, out_valid8;
    logic [3:0]  out_gray;
    logic [7:0]  out_gray8;
    logic [2:0]  out_sb, out_sb8;
`ifdef RGB2GRAY_THRESH_EN
    logic [3:0]  in_thr;
    logic [7:0]  in_thr8;
    logic [0:0]  out_bin, out_bin8, prev_bin;
`endif

    rgb2gray_pipe #(.CH_W(4), .OUT_W(4), .FRAC(10), .SB_W(3)) u_dut (
        .pclk(pclk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rgb(in_rgb), .in_mode(in_mode), .in_sb(in_sb),
`ifdef RGB2GRAY_THRESH_EN
        .in_thr(in_thr), .out_bin(out_bin),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray), .out_sb(out_sb)
    );

    rgb2gray_pipe #(.CH_W(4), .OUT_W(8), .FRAC(10), .SB_W(3)) u_dut8 (
        .pclk(pclk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in_rgb(in_rgb), .in_mode(in_mode), .in_sb(in_sb),
`ifdef RGB2GRAY_THRESH_EN
        .in_thr(in_thr8), .out_bin(out_bin8),
`endif
        .out_valid(out_valid8), .out_ready(out_ready), .out_gray(out_gray8), .out_sb(out_sb8)
    );

    typedef struct {
        int g4;
        int g8;
        int sb;
        int acc;
        int stl;
        int thr;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          stalls = 0;
    logic        prev_stall = 1'b0;
    logic [3:0]  prev_g;
    logic [7:0]  prev_g8;
    logic [2:0]  prev_sb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
        end
    endtask

    // Reference: weighted sum with the nominal FRAC=10 weights, round half up, clamp.
    function automatic int ref_y(input int r, input int g, input int b, input bit m);
        int a;
        int y;
        if (!m) a = (r + g + b) * 341;
        else    a = r * 306 + g * 601 + b * 117;
        y = (a + 512) / 1024;
        if (y > 15) y = 15;
        return y;
    endfunction

    function automatic int ref_of(input logic [11:0] rgb, input bit m);
        return ref_y(int'(rgb[11:8]), int'(rgb[7:4]), int'(rgb[3:0]), m);
    endfunction

    // One clock cycle: drive, check outputs before the edge, record acceptance, advance.
    task automatic step(input bit v, input logic [11:0] rgb, input bit m, input logic [2:0] sb,
                        input bit ordy, input int e4, input int e8, input int thr, output bit acc);
        exp_t e;
        in_valid  = v;
        in_rgb    = rgb;
        in_mode   = m;
        in_sb     = sb;
        out_ready = ordy;
`ifdef RGB2GRAY_THRESH_EN
        in_thr    = 4'(thr);
        in_thr8   = 8'(thr * 17);
`endif
        #1;
        check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        check("in_ready8", 32'(in_ready8), 32'(!(out_valid && !out_ready)));
        check("valid8_align", 32'(out_valid8), 32'(out_valid));
        if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_gray", 32'(out_gray), 32'(prev_g));
            check("hold_gray8", 32'(out_gray8), 32'(prev_g8));
            check("hold_sb", 32'(out_sb), 32'(prev_sb));
`ifdef RGB2GRAY_THRESH_EN
            check("hold_bin", 32'(out_bin), 32'(prev_bin));
`endif
        end
        if (out_valid && out_ready) begin
            check("out_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("gray", 32'(out_gray), e.g4);
                check("gray8", 32'(out_gray8), e.g8);
                check("sb", 32'(out_sb), e.sb);
                check("sb8", 32'(out_sb8), e.sb);
                if (e.stl == stalls) check("latency", cyc - e.acc, 32'd3);
`ifdef RGB2GRAY_THRESH_EN
                check("bin", 32'(out_bin), 32'(e.g4 >= e.thr));
                check("bin8", 32'(out_bin8), 32'(e.g8 >= e.thr * 17));
`endif
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_g     = out_gray;
        prev_g8    = out_gray8;
        prev_sb    = out_sb;
`ifdef RGB2GRAY_THRESH_EN
        prev_bin   = out_bin;
`endif
        if (out_valid && !out_ready) stalls++;
        acc = v && in_ready;
        if (acc) begin
            e.g4 = e4; e.g8 = e8; e.sb = int'(sb); e.acc = cyc; e.stl = stalls; e.thr = thr;
            q.push_back(e);
        end
        @(posedge pclk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        bit a;
        for (int k = 0; k < 20 && q.size() != 0; k++)
            step(1'b0, 12'h000, 1'b0, 3'd0, 1'b1, 0, 0, 8, a);
        check("drain_empty", q.size(), 32'd0);
    endtask

    logic [11:0] d_rgb [9];
    bit          d_m   [9];
    int          d_e4  [9];
    int          d_e8  [9];

    initial begin
        bit          a;
        int          y;
        int          idx;
        int          thr;
        logic [11:0] rgb;
        logic [11:0] s_rgb [16];
        bit          s_m   [16];

        d_rgb = '{12'hFFF, 12'h369, 12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFFF, 12'h888, 12'h777};
        d_m   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        d_e4  = '{15, 6, 0, 4, 9, 2, 15, 8, 7};
        d_e8  = '{255, 8'h66, 0, 8'h44, 8'h99, 8'h22, 255, 8'h88, 8'h77};

        rst_n = 1'b0; in_valid = 1'b0; in_rgb = '0; in_mode = 1'b0; in_sb = '0; out_ready = 1'b1;
`ifdef RGB2GRAY_THRESH_EN
        in_thr = 4'd8; in_thr8 = 8'h88;
`endif
        repeat (2) @(posedge pclk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_gray", 32'(out_gray), 32'd0);
        check("rst_sb", 32'(out_sb), 32'd0);
        rst_n = 1'b1;
        @(posedge pclk);
        cyc++;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Directed test-plan pixels, streamed back to back with threshold 8.
        for (int i = 0; i < 9; i++)
            step(1'b1, d_rgb[i], d_m[i], 3'(i), 1'b1, d_e4[i], d_e8[i], 8, a);
        drain();

        // Alternating weighting every pixel.
        for (int i = 0; i < 16; i++) begin
            rgb = 12'($urandom_range(4095));
            y = ref_of(rgb, i[0]);
            step(1'b1, rgb, i[0], 3'(i), 1'b1, y, y * 17, 8, a);
        end
        drain();

        // Sixteen-pixel stream with downstream stalled for cycles 5-8.
        for (int i = 0; i < 16; i++) begin
            s_rgb[i] = 12'($urandom_range(4095));
            s_m[i]   = 1'($urandom_range(1));
        end
        idx = 0;
        for (int t = 0; t < 40 && idx < 16; t++) begin
            y = ref_of(s_rgb[idx], s_m[idx]);
            step(1'b1, s_rgb[idx], s_m[idx], 3'(idx), !(t >= 5 && t <= 8), y, y * 17, 8, a);
            if (a) idx++;
        end
        check("stall_all_accepted", idx, 32'd16);
        drain();

        // Reset with three pixels in flight.
        for (int i = 0; i < 3; i++) begin
            rgb = 12'($urandom_range(4095));
            y = ref_of(rgb, 1'b1);
            step(1'b1, rgb, 1'b1, 3'(i + 1), 1'b1, y, y * 17, 8, a);
        end
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_gray", 32'(out_gray), 32'd0);
        check("async_rst_sb", 32'(out_sb), 32'd0);
        q.delete();
        prev_stall = 1'b0;
        @(posedge pclk);
        cyc++;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            step(1'b0, 12'h000, 1'b0, 3'd0, 1'b1, 0, 0, 8, a);
        check("no_stale_after_rst", 32'(out_valid), 32'd0);
        step(1'b1, 12'h369, 1'b0, 3'd5, 1'b1, 6, 8'h66, 8, a);
        drain();

        // Random traffic: random valid, mode, sideband, threshold and backpressure.
        for (int i = 0; i < 300; i++) begin
            rgb = 12'($urandom_range(4095));
            y = ref_of(rgb, 1'($urandom_range(1)));
            in_mode = 1'b0;
            thr = int'($urandom_range(15));
            begin
                bit m;
                m = 1'($urandom_range(1));
                y = ref_of(rgb, m);
                step(1'($urandom_range(3) != 0), rgb, m, 3'($urandom_range(7)),
                     1'($urandom_range(3) != 0), y, y * 17, thr, a);
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
